// File: rtl/hsi_m_reply_watchdog.sv
// Reply supervisor for HSI master commands: times start-bit gap and reply frame,
// classifies the outcome and requests repeats or a com-line switch.
module hsi_m_reply_watchdog #(
  parameter int T_START_TO = 2000,
  parameter int T_FRAME_TO = 40000,
  parameter int MAX_RETRY  = 2,
  parameter int TMR_W      = 16
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       ccw_accepted,
  input  logic [2:0] delays_after_cmds_for_reply,
  input  logic       rx_start_bit_accepted,
  input  logic       rx_frame_end,
  input  logic       rx_err,
  input  logic       rx_sd_busy,
  output logic [2:0] repeat_reqs,
  output logic       switch_com_src_req,
  output logic       reply_pending,
  output logic       link_fail
);

  localparam logic [1:0] S_IDLE       = 2'd0;
  localparam logic [1:0] S_WAIT_START = 2'd1;
  localparam logic [1:0] S_WAIT_END   = 2'd2;

  localparam logic [TMR_W-1:0] START_LAST = TMR_W'(T_START_TO - 1);
  localparam logic [TMR_W-1:0] FRAME_LAST = TMR_W'(T_FRAME_TO - 1);
  localparam logic [3:0]       RETRY_MAX  = 4'(MAX_RETRY);

  logic [1:0]       r_state;
  logic [TMR_W-1:0] r_timer;
  logic [2:0]       r_type;
  logic [3:0]       r_retry;
  logic [1:0]       r_sw;
  logic             r_link;
  logic [2:0]       r_rep;
  logic             r_swreq;
  logic             r_pending;

  logic [1:0]       w_state;
  logic [TMR_W-1:0] w_timer;
  logic [2:0]       w_type;
  logic [3:0]       w_retry;
  logic [3:0]       w_retry_inc;
  logic [1:0]       w_sw;
  logic             w_link;
  logic [2:0]       w_rep;
  logic             w_swreq;
  logic             w_good;
  logic             w_busy;
  logic             w_fail;

  // Several command bits at once: the highest index is the one supervised.
  function automatic logic [2:0] pick_type(input logic [2:0] dly);
    logic [2:0] t;
    t = 3'b000;
    if (dly[2])      t = 3'b100;
    else if (dly[1]) t = 3'b010;
    else if (dly[0]) t = 3'b001;
    return t;
  endfunction

  function automatic logic [1:0] sat_inc2(input logic [1:0] v);
    return (v == 2'd3) ? 2'd3 : v + 2'd1;
  endfunction

  always_comb begin
    w_state     = r_state;
    w_timer     = r_timer;
    w_type      = r_type;
    w_retry     = r_retry;
    w_retry_inc = r_retry + 4'd1;
    w_sw        = r_sw;
    w_link      = r_link;
    w_rep       = 3'b000;
    w_swreq     = 1'b0;
    w_good      = 1'b0;
    w_busy      = 1'b0;
    w_fail      = 1'b0;

    if (ccw_accepted) begin
      w_state = S_IDLE;
      w_timer = '0;
      w_type  = 3'b000;
      w_retry = 4'd0;
      w_sw    = 2'd0;
      w_link  = 1'b0;
    end else if (|delays_after_cmds_for_reply) begin
      // A new command restarts supervision; the old one is dropped without a repeat.
      w_state = S_WAIT_START;
      w_timer = '0;
      w_type  = pick_type(delays_after_cmds_for_reply);
    end else begin
      case (r_state)
        S_WAIT_START: begin
          if (rx_start_bit_accepted) begin
            w_state = S_WAIT_END;
            w_timer = '0;
          end else if (r_timer == START_LAST) begin
            w_fail = 1'b1;
          end else begin
            w_timer = r_timer + TMR_W'(1);
          end
        end
        S_WAIT_END: begin
          if (rx_frame_end) begin
            if (rx_err)          w_fail = 1'b1;
            else if (rx_sd_busy) w_busy = 1'b1;
            else                 w_good = 1'b1;
          end else if (r_timer == FRAME_LAST) begin
            w_fail = 1'b1;
          end else begin
            w_timer = r_timer + TMR_W'(1);
          end
        end
        default: ;
      endcase

      if (w_good || w_busy || w_fail) w_state = S_IDLE;

      if (w_good) begin
        w_retry = 4'd0;
        w_sw    = 2'd0;
        w_link  = 1'b0;
      end

      if (w_busy) w_rep = r_type;

      if (w_fail) begin
        w_rep = r_type;
        if (w_retry_inc < RETRY_MAX) begin
          w_retry = w_retry_inc;
        end else begin
          // Line exhausted: move to the other line; two exhausted lines mean link failure.
          w_retry = 4'd0;
          w_swreq = 1'b1;
          w_sw    = sat_inc2(r_sw);
          if (w_sw >= 2'd2) w_link = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state   <= S_IDLE;
      r_timer   <= '0;
      r_type    <= 3'b000;
      r_retry   <= 4'd0;
      r_sw      <= 2'd0;
      r_link    <= 1'b0;
      r_rep     <= 3'b000;
      r_swreq   <= 1'b0;
      r_pending <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_timer   <= w_timer;
      r_type    <= w_type;
      r_retry   <= w_retry;
      r_sw      <= w_sw;
      r_link    <= w_link;
      r_rep     <= w_rep;
      r_swreq   <= w_swreq;
      r_pending <= (w_state != S_IDLE);
    end
  end

  assign repeat_reqs        = r_rep;
  assign switch_com_src_req = r_swreq;
  assign reply_pending      = r_pending;
  assign link_fail          = r_link;

endmodule

// File: tb/tb_hsi_m_reply_watchdog.sv
// Bench for hsi_m_reply_watchdog: directed scenarios plus random traffic against
// a deadline-based reference model.
module tb_hsi_m_reply_watchdog;

  localparam int TS = 16;
  localparam int TF = 64;
  localparam int MR = 2;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       ccw_accepted;
  logic [2:0] delays_after_cmds_for_reply;
  logic       rx_start_bit_accepted;
  logic       rx_frame_end;
  logic       rx_err;
  logic       rx_sd_busy;
  logic [2:0] repeat_reqs;
  logic       switch_com_src_req;
  logic       reply_pending;
  logic       link_fail;

  always #5 clk = ~clk;

  hsi_m_reply_watchdog #(
    .T_START_TO(TS), .T_FRAME_TO(TF), .MAX_RETRY(MR), .TMR_W(16)
  ) dut (
    .clk(clk),
    .n_rst(n_rst),
    .ccw_accepted(ccw_accepted),
    .delays_after_cmds_for_reply(delays_after_cmds_for_reply),
    .rx_start_bit_accepted(rx_start_bit_accepted),
    .rx_frame_end(rx_frame_end),
    .rx_err(rx_err),
    .rx_sd_busy(rx_sd_busy),
    .repeat_reqs(repeat_reqs),
    .switch_com_src_req(switch_com_src_req),
    .reply_pending(reply_pending),
    .link_fail(link_fail)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model: phase 0 idle, 1 awaiting start bit, 2 awaiting frame end,
  // with an absolute cycle number at which the current phase times out.
  int         m_phase;
  int         m_deadline;
  logic [2:0] m_type;
  int         m_retry;
  int         m_sw;
  logic       m_link;
  logic [2:0] e_rep;
  logic       e_sw;
  logic       e_pend;
  logic       e_link;

  function automatic void model_reset();
    m_phase = 0; m_deadline = 0; m_type = 3'b000;
    m_retry = 0; m_sw = 0; m_link = 1'b0;
    e_rep = 3'b000; e_sw = 1'b0; e_pend = 1'b0; e_link = 1'b0;
  endfunction

  function automatic void model_step(input logic ccw, input logic [2:0] dly,
                                     input logic sb, input logic fe,
                                     input logic er, input logic bz);
    int outcome;  // 0 none, 1 good, 2 busy, 3 fail
    outcome = 0;
    e_rep = 3'b000;
    e_sw  = 1'b0;
    if (ccw) begin
      m_phase = 0; m_retry = 0; m_sw = 0; m_link = 1'b0; m_type = 3'b000;
    end else if (dly != 3'b000) begin
      m_phase = 1;
      m_type = dly[2] ? 3'b100 : (dly[1] ? 3'b010 : 3'b001);
      m_deadline = cyc + TS;
    end else if (m_phase == 1) begin
      if (sb) begin
        m_phase = 2;
        m_deadline = cyc + TF;
      end else if (cyc == m_deadline) outcome = 3;
    end else if (m_phase == 2) begin
      if (fe) outcome = er ? 3 : (bz ? 2 : 1);
      else if (cyc == m_deadline) outcome = 3;
    end
    if (outcome != 0) m_phase = 0;
    if (outcome == 1) begin
      m_retry = 0; m_sw = 0; m_link = 1'b0;
    end else if (outcome == 2) begin
      e_rep = m_type;
    end else if (outcome == 3) begin
      e_rep = m_type;
      m_retry = m_retry + 1;
      if (m_retry >= MR) begin
        m_retry = 0;
        e_sw = 1'b1;
        m_sw = (m_sw < 3) ? m_sw + 1 : 3;
        if (m_sw >= 2) m_link = 1'b1;
      end
    end
    e_pend = (m_phase != 0);
    e_link = m_link;
  endfunction

  task automatic tick(input logic ccw, input logic [2:0] dly, input logic sb,
                      input logic fe, input logic er, input logic bz);
    ccw_accepted = ccw;
    delays_after_cmds_for_reply = dly;
    rx_start_bit_accepted = sb;
    rx_frame_end = fe;
    rx_err = er;
    rx_sd_busy = bz;
    @(posedge clk);
    model_step(ccw, dly, sb, fe, er, bz);
    cyc++;
    @(negedge clk);
    ccw_accepted = 1'b0;
    delays_after_cmds_for_reply = 3'b000;
    rx_start_bit_accepted = 1'b0;
    rx_frame_end = 1'b0;
    rx_err = 1'b0;
    rx_sd_busy = 1'b0;
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    ccw_accepted = 1'b0;
    delays_after_cmds_for_reply = 3'b000;
    rx_start_bit_accepted = 1'b0;
    rx_frame_end = 1'b0;
    rx_err = 1'b0;
    rx_sd_busy = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (repeat_reqs !== 3'b000) begin errors++; $display("FAIL reset_rep got=%b exp=000", repeat_reqs); end
    checks++;
    if (switch_com_src_req !== 1'b0) begin errors++; $display("FAIL reset_sw got=%b exp=0", switch_com_src_req); end
    checks++;
    if (reply_pending !== 1'b0) begin errors++; $display("FAIL reset_pend got=%b exp=0", reply_pending); end
    checks++;
    if (link_fail !== 1'b0) begin errors++; $display("FAIL reset_lf got=%b exp=0", link_fail); end
    n_rst = 1'b1;
    cyc = 0;
  endtask

  task automatic test_good_reply();
    for (int k = 0; k <= 45; k++) begin
      tick(1'b0, (k == 0) ? 3'b001 : 3'b000, k == 5, k == 40, 1'b0, 1'b0);
      checks++;
      if ({repeat_reqs, switch_com_src_req, reply_pending, link_fail} !== {e_rep, e_sw, e_pend, e_link}) begin
        errors++;
        $display("FAIL good_model k=%0d got rep=%b sw=%b pend=%b lf=%b exp rep=%b sw=%b pend=%b lf=%b",
                 k, repeat_reqs, switch_com_src_req, reply_pending, link_fail, e_rep, e_sw, e_pend, e_link);
      end
      checks++;
      if (reply_pending !== (k <= 39) || repeat_reqs !== 3'b000) begin
        errors++;
        $display("FAIL good_pend k=%0d got pend=%b rep=%b exp pend=%b rep=000", k, reply_pending, repeat_reqs, k <= 39);
      end
    end
  endtask

  // Run one CCW start-bit timeout; expect_sw tells whether this attempt exhausts the line.
  task automatic test_start_timeout(input logic expect_sw);
    for (int k = 0; k <= 20; k++) begin
      tick(1'b0, (k == 0) ? 3'b100 : 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
      checks++;
      if ({repeat_reqs, switch_com_src_req, reply_pending, link_fail} !== {e_rep, e_sw, e_pend, e_link}) begin
        errors++;
        $display("FAIL tmo_model k=%0d got rep=%b sw=%b pend=%b lf=%b exp rep=%b sw=%b pend=%b lf=%b",
                 k, repeat_reqs, switch_com_src_req, reply_pending, link_fail, e_rep, e_sw, e_pend, e_link);
      end
      checks++;
      if (repeat_reqs !== ((k == 16) ? 3'b100 : 3'b000) ||
          switch_com_src_req !== ((k == 16) && expect_sw)) begin
        errors++;
        $display("FAIL tmo_pulse k=%0d got rep=%b sw=%b exp rep=%b sw=%b", k, repeat_reqs,
                 switch_com_src_req, (k == 16) ? 3'b100 : 3'b000, (k == 16) && expect_sw);
      end
    end
  endtask

  task automatic test_link_fail();
    tick(1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int a = 0; a < 4; a++) begin
      for (int k = 0; k <= 17; k++) begin
        tick(1'b0, (k == 0) ? 3'b010 : 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({repeat_reqs, switch_com_src_req, reply_pending, link_fail} !== {e_rep, e_sw, e_pend, e_link}) begin
          errors++;
          $display("FAIL lf_model a=%0d k=%0d got rep=%b sw=%b pend=%b lf=%b exp rep=%b sw=%b pend=%b lf=%b",
                   a, k, repeat_reqs, switch_com_src_req, reply_pending, link_fail, e_rep, e_sw, e_pend, e_link);
        end
        if (k == 16) begin
          checks++;
          if (repeat_reqs !== 3'b010 || switch_com_src_req !== (a == 1 || a == 3)) begin
            errors++;
            $display("FAIL lf_switch a=%0d got rep=%b sw=%b exp rep=010 sw=%b", a, repeat_reqs,
                     switch_com_src_req, a == 1 || a == 3);
          end
        end
      end
      checks++;
      if (link_fail !== (a == 3)) begin
        errors++;
        $display("FAIL lf_level a=%0d got=%b exp=%b", a, link_fail, a == 3);
      end
    end
    for (int k = 0; k <= 12; k++) begin
      tick(1'b0, (k == 0) ? 3'b010 : 3'b000, k == 2, k == 10, 1'b0, 1'b0);
      checks++;
      if (link_fail !== (k < 10)) begin
        errors++;
        $display("FAIL lf_clear k=%0d got=%b exp=%b", k, link_fail, k < 10);
      end
    end
  endtask

  task automatic test_err_busy();
    tick(1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int a = 0; a < 3; a++) begin
      for (int k = 0; k <= 12; k++) begin
        tick(1'b0, (k == 0) ? 3'b001 : 3'b000, k == 2, k == 10, a != 1, a != 2);
        checks++;
        if ({repeat_reqs, switch_com_src_req, reply_pending, link_fail} !== {e_rep, e_sw, e_pend, e_link}) begin
          errors++;
          $display("FAIL eb_model a=%0d k=%0d got rep=%b sw=%b pend=%b lf=%b exp rep=%b sw=%b pend=%b lf=%b",
                   a, k, repeat_reqs, switch_com_src_req, reply_pending, link_fail, e_rep, e_sw, e_pend, e_link);
        end
        if (k == 10) begin
          checks++;
          if (repeat_reqs !== 3'b001 || switch_com_src_req !== (a == 2)) begin
            errors++;
            $display("FAIL eb_class a=%0d got rep=%b sw=%b exp rep=001 sw=%b", a, repeat_reqs,
                     switch_com_src_req, a == 2);
          end
        end
      end
    end
  endtask

  task automatic test_ccw_abort();
    tick(1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k <= 17; k++) tick(1'b0, (k == 0) ? 3'b001 : 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k <= 20; k++) begin
      tick(k == 8, (k == 0) ? 3'b001 : 3'b000, k == 2, k == 12, 1'b0, 1'b0);
      checks++;
      if (reply_pending !== (k < 8) || repeat_reqs !== 3'b000 ||
          {switch_com_src_req, reply_pending, link_fail} !== {e_sw, e_pend, e_link}) begin
        errors++;
        $display("FAIL abort k=%0d got pend=%b rep=%b sw=%b lf=%b exp pend=%b rep=000 sw=%b lf=%b",
                 k, reply_pending, repeat_reqs, switch_com_src_req, link_fail, k < 8, e_sw, e_link);
      end
    end
    for (int k = 0; k <= 17; k++) begin
      tick(1'b0, (k == 0) ? 3'b001 : 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (repeat_reqs !== ((k == 16) ? 3'b001 : 3'b000) || switch_com_src_req !== 1'b0) begin
        errors++;
        $display("FAIL abort_cnt k=%0d got rep=%b sw=%b exp rep=%b sw=0", k, repeat_reqs,
                 switch_com_src_req, (k == 16) ? 3'b001 : 3'b000);
      end
    end
  endtask

  task automatic test_priority();
    tick(1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    // restart mid-wait with a multi-bit command: highest index supervised, old one dropped
    for (int k = 0; k <= 22; k++) begin
      tick(1'b0, (k == 0) ? 3'b001 : ((k == 3) ? 3'b110 : 3'b000), 1'b0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (repeat_reqs !== ((k == 19) ? 3'b100 : 3'b000) || repeat_reqs !== e_rep) begin
        errors++;
        $display("FAIL prio_restart k=%0d got rep=%b exp=%b", k, repeat_reqs, (k == 19) ? 3'b100 : 3'b000);
      end
    end
    // ccw_accepted swallows a same-cycle command
    for (int k = 0; k <= 20; k++) begin
      tick(k == 0, (k == 0) ? 3'b001 : 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (reply_pending !== 1'b0 || repeat_reqs !== 3'b000 || reply_pending !== e_pend) begin
        errors++;
        $display("FAIL prio_ccw k=%0d got pend=%b rep=%b exp pend=0 rep=000", k, reply_pending, repeat_reqs);
      end
    end
    // start bit on the timeout cycle, frame end on the timeout cycle: both win
    for (int k = 0; k <= 85; k++) begin
      tick(1'b0, (k == 0) ? 3'b010 : 3'b000, k == 16, k == 80, 1'b0, 1'b0);
      checks++;
      if (reply_pending !== (k < 80) || repeat_reqs !== 3'b000 || switch_com_src_req !== e_sw) begin
        errors++;
        $display("FAIL prio_edge k=%0d got pend=%b rep=%b exp pend=%b rep=000", k, reply_pending, repeat_reqs, k < 80);
      end
    end
    // new command on the timeout cycle discards the expiring supervision
    for (int k = 0; k <= 33; k++) begin
      tick(1'b0, (k == 0 || k == 16) ? 3'b001 : 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (repeat_reqs !== ((k == 32) ? 3'b001 : 3'b000) || repeat_reqs !== e_rep) begin
        errors++;
        $display("FAIL prio_dly_tmo k=%0d got rep=%b exp=%b", k, repeat_reqs, (k == 32) ? 3'b001 : 3'b000);
      end
    end
  endtask

  task automatic test_random();
    logic       ccw, sb, fe, er, bz;
    logic [2:0] dly;
    for (int i = 0; i < 3000; i++) begin
      ccw = ($urandom_range(0, 199) == 0);
      dly = ($urandom_range(0, 99) < 3) ? 3'($urandom_range(1, 7)) : 3'b000;
      sb  = ($urandom_range(0, 99) < 7);
      fe  = ($urandom_range(0, 99) < 4);
      er  = ($urandom_range(0, 3) == 0);
      bz  = ($urandom_range(0, 2) == 0);
      tick(ccw, dly, sb, fe, er, bz);
      checks++;
      if ({repeat_reqs, switch_com_src_req, reply_pending, link_fail} !== {e_rep, e_sw, e_pend, e_link}) begin
        errors++;
        $display("FAIL random i=%0d got rep=%b sw=%b pend=%b lf=%b exp rep=%b sw=%b pend=%b lf=%b",
                 i, repeat_reqs, switch_com_src_req, reply_pending, link_fail, e_rep, e_sw, e_pend, e_link);
      end
    end
  endtask

  initial begin
    test_reset();
    test_good_reply();
    test_start_timeout(1'b0);
    test_start_timeout(1'b1);
    test_link_fail();
    test_err_busy();
    test_ccw_abort();
    test_priority();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout simulation did not complete, checks=%0d", checks);
    $fatal(1);
  end

endmodule
